// File: rtl/nn_agent_env_pkg.sv
// Shared types and constants for the game environment that feeds the NN player.
// Move codes, lane count, FSM states and sensor bit positions live here.
package nn_agent_env_pkg;

   localparam logic [1:0] MOVE_LEFT  = 2'd0;
   localparam logic [1:0] MOVE_STAY  = 2'd1;
   localparam logic [1:0] MOVE_RIGHT = 2'd2;

   localparam int NUM_LANES = 3;
   localparam int SENS_W    = 6;

   localparam int SENS_R0_LEFT   = 0;
   localparam int SENS_R0_CENTER = 1;
   localparam int SENS_R0_RIGHT  = 2;
   localparam int SENS_R1_LEFT   = 3;
   localparam int SENS_R1_CENTER = 4;
   localparam int SENS_R1_RIGHT  = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_APPLY  = 3'd3,
      ST_OVER   = 3'd4
   } state_e;

   // Walls stop the player: left at lane 0 and right at the last lane are no-ops.
   function automatic logic [1:0] clamp_lane(input logic [1:0] lane, input logic [1:0] mv);
      logic [1:0] nl;
      nl = lane;
      if (mv == MOVE_LEFT && lane != 2'd0) begin
         nl = lane - 2'd1;
      end else if (mv == MOVE_RIGHT && lane < 2'(NUM_LANES - 1)) begin
         nl = lane + 2'd1;
      end
      return nl;
   endfunction

   // A fully blocked row would make the game unwinnable, so it is opened up.
   function automatic logic [2:0] sanitize_row(input logic [2:0] row);
      return (row == 3'b111) ? 3'b101 : row;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/nn_agent_env_sensor.sv
// Combinational sensor encoder: the two nearest obstacle rows seen from the player lane.
// Each row yields {right, center, left}; walls read as obstacles.
module nn_sensor_encode
   import nn_agent_env_pkg::*;
(
   input  logic [2:0]        row0_i,
   input  logic [2:0]        row1_i,
   input  logic [1:0]        lane_i,
   output logic [SENS_W-1:0] sens_o
);

   function automatic logic [2:0] encode_row(input logic [2:0] row, input logic [1:0] p);
      logic [2:0] s;
      case (p)
         2'd0:    s = {row[1], row[0], 1'b1};
         2'd2:    s = {1'b1, row[2], row[1]};
         default: s = {row[2], row[1], row[0]};
      endcase
      return s;
   endfunction

   always_comb begin
      sens_o = '0;
      sens_o[SENS_R0_LEFT +: 3] = encode_row(row0_i, lane_i);
      sens_o[SENS_R1_LEFT +: 3] = encode_row(row1_i, lane_i);
   end

endmodule

// File: rtl/nn_agent_env.sv
// 3-lane obstacle game that presents sensors to the NN, samples its move after a
// settle window, applies it, scrolls the field and keeps a saturating survival score.
module nn_agent_env
   import nn_agent_env_pkg::*;
#(
   parameter int          TICK_DIV      = 8,
   parameter int          SETTLE_CYCLES = 2,
   parameter int          ROWS          = 4,
   parameter int          SCORE_W       = 16,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 load_en_i,
   input  logic [3*ROWS-1:0]    load_field_i,
   input  logic [1:0]           load_lane_i,
   input  logic [1:0]           move_i,
   output logic [SENS_W-1:0]    sens_o,
   output logic [1:0]           lane_o,
   output logic [3*ROWS-1:0]    field_o,
   output logic [SCORE_W-1:0]   score_o,
   output logic                 busy_o,
   output logic                 game_over_o,
   output state_e               state_o
);

   localparam int FW       = 3 * ROWS;
   localparam int TICK_W   = $clog2(TICK_DIV);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   state_e               state_q, state_d;
   logic [1:0]           lane_q, lane_d;
   logic [FW-1:0]        field_q, field_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SENS_W-1:0]    sens_q, sens_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [1:0]           move_q, move_d;

   logic [SENS_W-1:0]    sens_enc;
   logic [1:0]           load_lane_norm;
   logic [1:0]           new_lane;
   logic [2:0]           row0;
   logic                 collision;
   logic                 tick_done;
   logic                 settle_done;

   nn_sensor_encode u_sensor_encode (
      .row0_i (field_q[2:0]),
      .row1_i (field_q[5:3]),
      .lane_i (lane_q),
      .sens_o (sens_enc)
   );

   assign load_lane_norm = (load_lane_i == 2'd3) ? 2'd1 : load_lane_i;
   assign tick_done      = (state_q == ST_WAIT)   && (tick_cnt_q == TICK_LAST);
   assign settle_done    = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);
   assign new_lane       = clamp_lane(lane_q, move_q);
   assign row0           = field_q[2:0];
   // Collision is judged against the field as it was before this tick's scroll.
   assign collision      = row0[new_lane];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_i) state_d = ST_WAIT;
         ST_WAIT:   if (tick_done) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_done) state_d = ST_APPLY;
         ST_APPLY:  state_d = collision ? ST_OVER : ST_WAIT;
         ST_OVER:   if (start_i) state_d = ST_WAIT;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q == ST_WAIT) || (state_q == ST_SETTLE) || (state_q == ST_APPLY);
      game_over_o = (state_q == ST_OVER);
      state_o     = state_q;
   end

   always_comb begin
      lane_d       = lane_q;
      field_d      = field_q;
      score_d      = score_q;
      sens_d       = sens_q;
      lfsr_d       = lfsr_q;
      tick_cnt_d   = tick_cnt_q;
      settle_cnt_d = settle_cnt_q;
      move_d       = move_q;
      case (state_q)
         ST_IDLE: begin
            sens_d = '0;
            if (load_en_i) begin
               field_d = load_field_i;
               lane_d  = load_lane_norm;
            end
         end
         ST_OVER: begin
            sens_d = '0;
            if (start_i) begin
               lane_d  = 2'd1;
               field_d = '0;
               score_d = '0;
            end
         end
         ST_WAIT: begin
            if (tick_done) begin
               tick_cnt_d = '0;
               sens_d     = sens_enc;
            end else begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
         end
         ST_SETTLE: begin
            if (settle_done) begin
               settle_cnt_d = '0;
               move_d       = move_i;
            end else begin
               settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
         end
         ST_APPLY: begin
            lane_d  = new_lane;
            field_d = {sanitize_row(lfsr_q[2:0]), field_q[FW-1:3]};
            lfsr_d  = lfsr_next(lfsr_q);
            if (collision) begin
               sens_d = '0;
            end else if (score_q != {SCORE_W{1'b1}}) begin
               score_d = score_q + SCORE_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q       <= 2'd1;
         field_q      <= '0;
         score_q      <= '0;
         sens_q       <= '0;
         lfsr_q       <= LFSR_SEED;
         tick_cnt_q   <= '0;
         settle_cnt_q <= '0;
         move_q       <= MOVE_STAY;
      end else begin
         lane_q       <= lane_d;
         field_q      <= field_d;
         score_q      <= score_d;
         sens_q       <= sens_d;
         lfsr_q       <= lfsr_d;
         tick_cnt_q   <= tick_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         move_q       <= move_d;
      end
   end

   assign sens_o  = sens_q;
   assign lane_o  = lane_q;
   assign field_o = field_q;
   assign score_o = score_q;

endmodule

// File: tb/tb_nn_agent_env.sv
// Bench for nn_agent_env: directed game scenarios with literal expectations, then
// randomized play, all compared every cycle against a tick-level game model.
module tb_nn_agent_env;
   import nn_agent_env_pkg::*;

   localparam int TICK_DIV      = 4;
   localparam int SETTLE_CYCLES = 2;
   localparam int ROWS          = 4;
   localparam int SCORE_W       = 4;
   localparam int FW            = 3 * ROWS;
   localparam int PERIOD        = TICK_DIV + SETTLE_CYCLES + 1;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               load_en = 1'b0;
   logic [FW-1:0]      load_field = '0;
   logic [1:0]         load_lane = 2'd1;
   logic [1:0]         move = 2'd1;
   logic [5:0]         sens;
   logic [1:0]         lane;
   logic [FW-1:0]      field;
   logic [SCORE_W-1:0] score;
   logic               busy;
   logic               game_over;
   state_e             state_dbg;
   state_e             prev_state = ST_IDLE;

   int          checks = 0;
   int          failures = 0;
   bit          chk_en = 1'b0;
   int unsigned cyc_ctr = 0;
   int unsigned settle_q[$];

   always #5 clk = ~clk;

   nn_agent_env #(
      .TICK_DIV      (TICK_DIV),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .ROWS          (ROWS),
      .SCORE_W       (SCORE_W),
      .LFSR_SEED     (LFSR_SEED)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .load_en_i    (load_en),
      .load_field_i (load_field),
      .load_lane_i  (load_lane),
      .move_i       (move),
      .sens_o       (sens),
      .lane_o       (lane),
      .field_o      (field),
      .score_o      (score),
      .busy_o       (busy),
      .game_over_o  (game_over),
      .state_o      (state_dbg)
   );

   // ---------------- game model: cyc is the position inside the current tick
   typedef struct {
      bit                 running;
      bit                 over;
      int                 cyc;
      bit [1:0]           lane;
      bit [FW-1:0]        field;
      bit [SCORE_W-1:0]   score;
      bit [5:0]           sens;
      bit [15:0]          lfsr;
      bit [1:0]           mv;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.running = 1'b0;
      r.over    = 1'b0;
      r.cyc     = 0;
      r.lane    = 2'd1;
      r.field   = '0;
      r.score   = '0;
      r.sens    = '0;
      r.lfsr    = LFSR_SEED;
      r.mv      = 2'd1;
      return r;
   endfunction

   function automatic int lane_after(input int p, input bit [1:0] mv);
      int n;
      n = p + ((mv == 2'd0) ? -1 : (mv == 2'd2) ? 1 : 0);
      if (n < 0) n = 0;
      if (n > 2) n = 2;
      return n;
   endfunction

   // Pad each row with wall bits on both sides, then take a 3-wide window at the lane.
   function automatic bit [5:0] exp_sens(input bit [FW-1:0] f, input bit [1:0] p);
      bit [4:0] w0;
      bit [4:0] w1;
      int q;
      q  = (p == 2'd3) ? 1 : int'(p);
      w0 = {1'b1, f[2:0], 1'b1};
      w1 = {1'b1, f[5:3], 1'b1};
      return {3'(w1 >> q), 3'(w0 >> q)};
   endfunction

   function automatic model_t model_step(input model_t c, input bit st, input bit ld,
                                         input bit [FW-1:0] lf, input bit [1:0] ll,
                                         input bit [1:0] mv);
      model_t n;
      int nl;
      bit [2:0] top;
      n = c;
      if (!c.running && !c.over) begin
         if (ld) begin
            n.field = lf;
            n.lane  = (ll == 2'd3) ? 2'd1 : ll;
         end
         if (st) begin
            n.running = 1'b1;
            n.cyc     = 0;
         end
      end else if (c.over) begin
         if (st) begin
            n.over = 1'b0; n.running = 1'b1; n.cyc = 0;
            n.lane = 2'd1; n.field = '0; n.score = '0;
         end
      end else begin
         if (c.cyc == TICK_DIV - 1) n.sens = exp_sens(c.field, c.lane);
         if (c.cyc == TICK_DIV + SETTLE_CYCLES - 1) n.mv = mv;
         if (c.cyc == PERIOD - 1) begin
            nl  = lane_after(int'(c.lane), c.mv);
            top = c.lfsr[2:0];
            if (top == 3'b111) top = 3'b101;
            n.field = (c.field >> 3) | (FW'(top) << (FW - 3));
            n.lfsr  = {c.lfsr[14:0], c.lfsr[15] ^ c.lfsr[13] ^ c.lfsr[12] ^ c.lfsr[10]};
            n.lane  = nl[1:0];
            if (c.field[nl]) begin
               n.running = 1'b0; n.over = 1'b1; n.sens = '0;
            end else if (c.score != '1) begin
               n.score = c.score + 1'b1;
            end
            n.cyc = 0;
         end else begin
            n.cyc = c.cyc + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, start, load_en, load_field, load_lane, move);
   end

   always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

   // ---------------- scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("sens",      32'(sens),      32'(m.sens));
         check("lane",      32'(lane),      32'(m.lane));
         check("field",     32'(field),     32'(m.field));
         check("score",     32'(score),     32'(m.score));
         check("busy",      32'(busy),      32'(m.running));
         check("game_over", 32'(game_over), 32'(m.over));
      end
      if (state_dbg == ST_SETTLE && prev_state != ST_SETTLE) settle_q.push_back(cyc_ctr);
      prev_state <= state_dbg;
   end

   // ---------------- drivers (inputs change on the falling edge)
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; load_en = 1'b0; move = 2'd1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic preload_start(input logic [FW-1:0] f, input logic [1:0] l);
      load_en = 1'b1; load_field = f; load_lane = l; start = 1'b1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
   endtask

   task automatic start_only();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One full tick from WAIT entry; mv_late is applied right after the sample edge.
   task automatic play_tick(input logic [1:0] mv, input logic [1:0] mv_late, output logic [5:0] s);
      move = mv;
      repeat (TICK_DIV) @(negedge clk);
      s = sens;
      repeat (SETTLE_CYCLES) @(negedge clk);
      move = mv_late;
      @(negedge clk);
   endtask

   // Search all move sequences over the visible rows for one that survives them.
   function automatic logic [1:0] pick_move(input bit [FW-1:0] f, input bit [1:0] p);
      int c;
      int pos;
      bit ok;
      logic [1:0] first;
      logic [1:0] mv;
      for (int code = 0; code < 81; code++) begin
         c = code; pos = int'(p); ok = 1'b1; first = 2'd1;
         for (int k = 0; k < ROWS; k++) begin
            mv  = (c % 3 == 0) ? 2'd1 : (c % 3 == 1) ? 2'd0 : 2'd2;
            c   = c / 3;
            pos = lane_after(pos, mv);
            if (f[3 * k + pos]) ok = 1'b0;
            if (k == 0) first = mv;
         end
         if (ok) return first;
      end
      return 2'd1;
   endfunction

   initial begin
      logic [5:0] s;
      logic [1:0] mv;
      int sat_ticks;

      do_reset();
      chk_en = 1'b1;

      // reset values and a first quiet tick
      check("rst_sens",  32'(sens),      32'd0);
      check("rst_lane",  32'(lane),      32'd1);
      check("rst_field", 32'(field),     32'd0);
      check("rst_score", 32'(score),     32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      preload_start(12'h001, 2'd1);
      play_tick(2'd1, 2'd1, s);
      check("t1_sens",  32'(s),         32'b000001);
      check("t1_lane",  32'(lane),      32'd1);
      check("t1_score", 32'(score),     32'd1);
      check("t1_over",  32'(game_over), 32'd0);

      // dodge left, then the obstacle from row 1 arrives in our lane
      do_reset();
      preload_start(12'h00A, 2'd1);
      play_tick(2'd0, 2'd0, s);
      check("t2_sens_a", 32'(s),     32'b001010);
      check("t2_lane_a", 32'(lane),  32'd0);
      check("t2_score",  32'(score), 32'd1);
      play_tick(2'd1, 2'd1, s);
      check("t2_sens_b", 32'(s),         32'b001011);
      check("t2_over",   32'(game_over), 32'd1);
      check("t2_score2", 32'(score),     32'd1);
      check("t2_busy",   32'(busy),      32'd0);

      // walls on both sides, and lane 3 preload
      do_reset();
      preload_start('0, 2'd0);
      play_tick(2'd0, 2'd0, s);
      check("t3_sens_l", 32'(s),    32'b001001);
      check("t3_lane_l", 32'(lane), 32'd0);
      do_reset();
      preload_start('0, 2'd2);
      play_tick(2'd2, 2'd2, s);
      check("t3_sens_r", 32'(s),    32'b100100);
      check("t3_lane_r", 32'(lane), 32'd2);
      do_reset();
      preload_start('0, 2'd3);
      check("t3_lane3", 32'(lane), 32'd1);

      // tick period and sample point
      do_reset();
      preload_start('0, 2'd1);
      settle_q.delete();
      play_tick(2'd0, 2'd2, s);
      check("t4_late_ignored", 32'(lane), 32'd0);
      play_tick(2'd2, 2'd0, s);
      check("t4_sampled", 32'(lane), 32'd1);
      if (settle_q.size() < 2) check("t4_settle_count", 32'(settle_q.size()), 32'd2);
      else check("t4_period", 32'(settle_q[1] - settle_q[0]), 32'(PERIOD));

      // asynchronous reset in the middle of SETTLE
      do_reset();
      preload_start(12'h004, 2'd1);
      play_tick(2'd0, 2'd0, s);
      check("t5_sens_a", 32'(s), 32'b000100);
      move = 2'd1;
      repeat (TICK_DIV + 1) @(negedge clk);
      check("t5_pre_sens", 32'(sens), 32'b001001);
      #2 rst_n = 1'b0;
      #1;
      check("t5_state", 32'(state_dbg), 32'(ST_IDLE));
      check("t5_lane",  32'(lane),      32'd1);
      check("t5_score", 32'(score),     32'd0);
      check("t5_sens",  32'(sens),      32'd0);
      check("t5_busy",  32'(busy),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_only();
      play_tick(2'd1, 2'd1, s);
      check("t5_after_score", 32'(score), 32'd1);
      check("t5_after_lane",  32'(lane),  32'd1);

      // score saturation with obstacle avoidance
      do_reset();
      preload_start('0, 2'd1);
      sat_ticks = 0;
      for (int t = 0; t < 200 && sat_ticks < 5; t++) begin
         if (m.over) start_only();
         mv = pick_move(m.field, m.lane);
         play_tick(mv, mv, s);
         check("t6_top_row_open", 32'(field[FW-1 -: 3] == 3'b111), 32'd0);
         if (m.running && m.score == '1) sat_ticks++;
      end
      check("t6_score_sat", 32'(score), 32'hF);

      // randomized play: moves every cycle, stray starts/loads, occasional reset
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         move       = 2'($urandom_range(0, 3));
         start      = ($urandom_range(0, 11) == 0);
         load_en    = ($urandom_range(0, 2) == 0);
         load_field = FW'($urandom);
         load_lane  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 699) == 0) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      start = 1'b0;
      load_en = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
